cpu_if_gen: RTL and testbench
=============================

Name: cpu_if_gen

Overview:
Parametrised CPU slave interface between the host bus and the accelerator. It decodes host writes into per-bank weight SRAM, bias and image write strobes, and returns indexed result words on reads. It adds a control/status page with a start/done handshake to the compute core, a run-cycle counter, an interrupt, and a read-valid strobe.

Parameters:
ADR_W, 18, host byte-address width; page field is ADR[ADR_W-1:12], word offset is ADR[11:2]
DATA_W, 32, host and SRAM data width
NUM_BANK, 46, number of weight SRAM banks, mapped to pages 0..NUM_BANK-1; must be <= BIAS_PAGE
NUM_RESULT, 46, number of result words readable; must be <= 1024
BIAS_PAGE, 6'h2E, bias memory page
IMAGE_PAGE, 6'h30, image memory page
RESULT_PAGE, 6'h31, result read page
CTRL_PAGE, 6'h32, control/status page

Ports:
CLK  in  1  clock
RESET_X  in  1  asynchronous active-low reset
CPU_WR  in  1  write strobe, one cycle per access
CPU_RD  in  1  read strobe, one cycle per access
CPU_ADR  in  ADR_W  byte address
CPU_WDATA  in  DATA_W  write data
CPU_RDATA  out  DATA_W  read data, valid while CPU_RVALID=1
CPU_RVALID  out  1  one-cycle read-data-valid pulse
CPU_IRQ  out  1  level interrupt, DONE & IRQ_EN
SRAM_WE  out  NUM_BANK  one-hot weight-bank write enable
BIAS_WE  out  1  bias write enable
IMAGE_WE  out  1  image write enable
MEM_ADR  out  10  word address (CPU_ADR[11:2])
MEM_WDATA  out  DATA_W  write data to all memories
RESULT_BUS  in  NUM_RESULT*DATA_W  flattened results; word i is bits [i*DATA_W +: DATA_W]
CORE_START  out  1  one-cycle start pulse to the compute core
CORE_DONE  in  1  one-cycle completion pulse from the core

Behaviour:
- Reset: every output is 0, FSM is IDLE, and all registers (IRQ_EN, DONE, CYCLES) are 0.
- Write path, 1-cycle latency: on CPU_WR the next cycle gives MEM_ADR/MEM_WDATA captured and exactly one of SRAM_WE[p], BIAS_WE or IMAGE_WE high for one cycle, chosen by page p. Writes to other pages produce no memory strobe. MEM_ADR/MEM_WDATA hold their values when idle.
- Read path, 1-cycle latency: CPU_RD gives CPU_RVALID=1 with CPU_RDATA the next cycle. The following cycle CPU_RVALID=0 and CPU_RDATA=0.
  - RESULT_PAGE, offset k < NUM_RESULT: result word k, sampled in the RD cycle.
  - RESULT_PAGE, offset k >= NUM_RESULT: 0.
  - CTRL_PAGE: registers below.
  - Every other page: reads 0 (memories are write-only from the host).
- CPU_WR and CPU_RD in the same cycle: the write is performed; the read returns 0 with CPU_RVALID=1.
- CTRL_PAGE registers:
  - 0x000 CTRL: bit0 START (write-1 requests a start, reads 0); bit1 IRQ_EN (read/write).
  - 0x004 STATUS: bit0 BUSY (read-only); bit1 DONE (sticky, write-1-to-clear).
  - 0x008 CYCLES: read-only count of cycles of the last or current run.
  - Other offsets read 0 and ignore writes.
- Run FSM:
  - IDLE: a write of START=1 → RUN. In the cycle after the write: CORE_START=1 for one cycle, BUSY=1, CYCLES=0, DONE cleared.
  - RUN: CYCLES increments every cycle and saturates at all-ones. CORE_DONE=1 → IDLE next cycle with BUSY=0 and DONE=1; CYCLES freezes at the value it held when CORE_DONE was seen.
  - START written while in RUN is ignored: no second CORE_START and no counter reset. The IRQ_EN bit of that same write still takes effect.
  - CORE_DONE while in IDLE is ignored.
  - DONE W1C in the same cycle that DONE is set: set wins.
- CPU_IRQ is registered: CPU_IRQ = DONE & IRQ_EN, one cycle after either changes.
- RESET_X low at any time, including mid-run, immediately forces IDLE and all outputs to 0. No CORE_START is issued on reset release.

Test Plan:
- Reset then no activity → every output stays 0 for 20 cycles; reading CTRL 0x004 returns 0.
- WR at 0x2D010 with data 0xDEADBEEF → next cycle SRAM_WE=1<<45, MEM_ADR=4, MEM_WDATA=0xDEADBEEF; one cycle later SRAM_WE=0. WR at 0x2E000 → BIAS_WE pulse. WR at 0x30000 → IMAGE_WE pulse. WR at 0x2F000 → no strobe.
- RESULT_BUS word i = 0x1000+i. RD at 0x31000+4*i for i=0,9,10,45 → CPU_RVALID pulse with 0x1000+i each time. RD at 0x310B8 (k=46) → 0.
- Write CTRL=0x3 → CORE_START for one cycle. Drive CORE_DONE 100 cycles later → STATUS=0x2, CYCLES=100, CPU_IRQ=1 one cycle later. Write STATUS=0x2 → CPU_IRQ deasserts.
- START rewritten mid-run → no extra CORE_START and CYCLES keeps counting. RESET_X pulsed mid-run → BUSY=0, CORE_START=0, CYCLES=0.
- Same-cycle WR to bank 3 and RD → SRAM_WE[3] pulse, CPU_RVALID=1 with CPU_RDATA=0.

Source files
------------

// File: rtl/cpu_if_gen.sv
// cpu_if_gen: host-bus slave for the accelerator. Decodes host writes into
// weight-bank / bias / image write strobes, serves result words and a small
// control/status page, and runs the start/done handshake with the compute core.
module cpu_if_gen #(
  parameter int                ADR_W       = 18,
  parameter int                DATA_W      = 32,
  parameter int                NUM_BANK    = 46,
  parameter int                NUM_RESULT  = 46,
  parameter logic [ADR_W-13:0] BIAS_PAGE   = 6'h2E,
  parameter logic [ADR_W-13:0] IMAGE_PAGE  = 6'h30,
  parameter logic [ADR_W-13:0] RESULT_PAGE = 6'h31,
  parameter logic [ADR_W-13:0] CTRL_PAGE   = 6'h32
) (
  input  logic                         CLK,
  input  logic                         RESET_X,
  input  logic                         CPU_WR,
  input  logic                         CPU_RD,
  input  logic [ADR_W-1:0]             CPU_ADR,
  input  logic [DATA_W-1:0]            CPU_WDATA,
  output logic [DATA_W-1:0]            CPU_RDATA,
  output logic                         CPU_RVALID,
  output logic                         CPU_IRQ,
  output logic [NUM_BANK-1:0]          SRAM_WE,
  output logic                         BIAS_WE,
  output logic                         IMAGE_WE,
  output logic [9:0]                   MEM_ADR,
  output logic [DATA_W-1:0]            MEM_WDATA,
  input  logic [NUM_RESULT*DATA_W-1:0] RESULT_BUS,
  output logic                         CORE_START,
  input  logic                         CORE_DONE
);

  localparam int PAGE_W = ADR_W - 12;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  state_t              next_state;
  logic [PAGE_W-1:0]   page;
  logic [9:0]          offset;
  logic                ctrl_sel;
  logic                wr_ctrl;
  logic                wr_status;
  logic                start_req;
  logic                start_accept;
  logic                run_end;
  logic                busy;
  logic                irq_en;
  logic                done;
  logic [DATA_W-1:0]   cycles;
  logic [NUM_BANK-1:0] bank_hit;
  logic [DATA_W-1:0]   rd_word;

  assign page      = CPU_ADR[ADR_W-1:12];
  assign offset    = CPU_ADR[11:2];
  assign ctrl_sel  = (page == CTRL_PAGE);
  assign wr_ctrl   = CPU_WR && ctrl_sel && (offset == 10'd0);
  assign wr_status = CPU_WR && ctrl_sel && (offset == 10'd1);
  assign start_req = wr_ctrl && CPU_WDATA[0];
  assign busy      = (state == RUN);

  // Run state register; reset drops any run in progress straight back to idle
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: a START write launches a run only from idle, and the
  // core's done pulse only ends a run that is actually in progress
  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    run_end      = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          next_state   = RUN;
          start_accept = 1'b1;
        end
      end
      RUN: begin
        if (CORE_DONE) begin
          next_state = IDLE;
          run_end    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control registers: start pulse, IRQ enable, sticky DONE (set beats clear),
  // saturating run-cycle counter that freezes on the cycle done is seen, and
  // the registered interrupt level
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      CORE_START <= 1'b0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      cycles     <= '0;
      CPU_IRQ    <= 1'b0;
    end else begin
      CORE_START <= start_accept;
      if (wr_ctrl) irq_en <= CPU_WDATA[1];
      if (run_end) done <= 1'b1;
      else if (start_accept || (wr_status && CPU_WDATA[1])) done <= 1'b0;
      if (start_accept) cycles <= '0;
      else if (busy && !CORE_DONE && (cycles != '1)) cycles <= cycles + DATA_W'(1);
      CPU_IRQ <= done & irq_en;
    end
  end

  // One-hot bank select from the page number
  always_comb begin
    bank_hit = '0;
    for (int i = 0; i < NUM_BANK; i++) bank_hit[i] = (page == PAGE_W'(i));
  end

  // Write path: capture address/data on every host write and pulse the one
  // strobe belonging to the addressed page; address/data hold between writes
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      SRAM_WE   <= '0;
      BIAS_WE   <= 1'b0;
      IMAGE_WE  <= 1'b0;
      MEM_ADR   <= '0;
      MEM_WDATA <= '0;
    end else if (CPU_WR) begin
      SRAM_WE   <= bank_hit;
      BIAS_WE   <= (page == BIAS_PAGE);
      IMAGE_WE  <= (page == IMAGE_PAGE);
      MEM_ADR   <= offset;
      MEM_WDATA <= CPU_WDATA;
    end else begin
      SRAM_WE   <= '0;
      BIAS_WE   <= 1'b0;
      IMAGE_WE  <= 1'b0;
    end
  end

  // Read mux: result words and control registers; everything else reads zero
  always_comb begin
    rd_word = '0;
    case (page)
      RESULT_PAGE: begin
        for (int i = 0; i < NUM_RESULT; i++) begin
          if (offset == 10'(i)) rd_word = RESULT_BUS[i*DATA_W +: DATA_W];
        end
      end
      CTRL_PAGE: begin
        case (offset)
          10'd0:   rd_word[1] = irq_en;
          10'd1:   rd_word[1:0] = {done, busy};
          10'd2:   rd_word = cycles;
          default: rd_word = '0;
        endcase
      end
      default: rd_word = '0;
    endcase
  end

  // Read return: one-cycle valid pulse; a read colliding with a write returns 0
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      CPU_RVALID <= 1'b0;
      CPU_RDATA  <= '0;
    end else begin
      CPU_RVALID <= CPU_RD;
      CPU_RDATA  <= (CPU_RD && !CPU_WR) ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_cpu_if_gen.sv
// tb_cpu_if_gen: self-checking bench for cpu_if_gen. Expected values come from
// a page/offset address model, a copy of the result words and a cycle count
// kept by the bench while it drives the core handshake.
module tb_cpu_if_gen;

  localparam int DATA_W     = 32;
  localparam int NUM_BANK   = 46;
  localparam int NUM_RESULT = 46;
  localparam logic [17:0] CTRL_BASE = 18'h32000;

  logic                         CLK;
  logic                         RESET_X;
  logic                         CPU_WR;
  logic                         CPU_RD;
  logic [17:0]                  CPU_ADR;
  logic [DATA_W-1:0]            CPU_WDATA;
  logic [DATA_W-1:0]            CPU_RDATA;
  logic                         CPU_RVALID;
  logic                         CPU_IRQ;
  logic [NUM_BANK-1:0]          SRAM_WE;
  logic                         BIAS_WE;
  logic                         IMAGE_WE;
  logic [9:0]                   MEM_ADR;
  logic [DATA_W-1:0]            MEM_WDATA;
  logic [NUM_RESULT*DATA_W-1:0] RESULT_BUS;
  logic                         CORE_START;
  logic                         CORE_DONE;

  int passed;
  int total;
  logic [DATA_W-1:0] result_words [NUM_RESULT];
  logic              model_irq_en;
  int                last_cycles;

  cpu_if_gen dut (
    .CLK        (CLK),
    .RESET_X    (RESET_X),
    .CPU_WR     (CPU_WR),
    .CPU_RD     (CPU_RD),
    .CPU_ADR    (CPU_ADR),
    .CPU_WDATA  (CPU_WDATA),
    .CPU_RDATA  (CPU_RDATA),
    .CPU_RVALID (CPU_RVALID),
    .CPU_IRQ    (CPU_IRQ),
    .SRAM_WE    (SRAM_WE),
    .BIAS_WE    (BIAS_WE),
    .IMAGE_WE   (IMAGE_WE),
    .MEM_ADR    (MEM_ADR),
    .MEM_WDATA  (MEM_WDATA),
    .RESULT_BUS (RESULT_BUS),
    .CORE_START (CORE_START),
    .CORE_DONE  (CORE_DONE)
  );

  // Free-running clock, 10 time units per period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Copy the model's result words onto the flattened bus
  task automatic load_results();
    for (int i = 0; i < NUM_RESULT; i++) RESULT_BUS[i*DATA_W +: DATA_W] = result_words[i];
  endtask

  // One host write cycle; returns at the negedge where the write's effects are visible
  task automatic do_write(input logic [17:0] adr, input logic [31:0] data);
    CPU_ADR = adr;
    CPU_WDATA = data;
    CPU_WR = 1'b1;
    @(negedge CLK);
    CPU_WR = 1'b0;
  endtask

  // One host read cycle; returns the data/valid seen in the following cycle
  task automatic do_read(input logic [17:0] adr, output logic [31:0] data, output logic valid);
    CPU_ADR = adr;
    CPU_RD = 1'b1;
    @(negedge CLK);
    CPU_RD = 1'b0;
    data = CPU_RDATA;
    valid = CPU_RVALID;
  endtask

  // Reset state and quiet outputs after release, then an idle STATUS read
  task automatic test_reset();
    logic [31:0] d;
    logic v;
    RESET_X = 1'b0;
    CPU_WR = 1'b0;
    CPU_RD = 1'b0;
    CPU_ADR = '0;
    CPU_WDATA = '0;
    CORE_DONE = 1'b0;
    RESULT_BUS = '0;
    model_irq_en = 1'b0;
    last_cycles = 0;
    repeat (3) @(negedge CLK);
    total++;
    if ({CPU_RDATA, CPU_RVALID, CPU_IRQ, SRAM_WE, BIAS_WE, IMAGE_WE, MEM_ADR, MEM_WDATA, CORE_START} !== '0)
      $display("[TB] FAIL reset_outputs: got rdata=%h rvalid=%b irq=%b sram=%h start=%b, want all 0",
               CPU_RDATA, CPU_RVALID, CPU_IRQ, SRAM_WE, CORE_START);
    else passed++;
    RESET_X = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      total++;
      if ({CPU_RDATA, CPU_RVALID, CPU_IRQ, SRAM_WE, BIAS_WE, IMAGE_WE, MEM_ADR, MEM_WDATA, CORE_START} !== '0)
        $display("[TB] FAIL idle_outputs cycle %0d: got rdata=%h rvalid=%b irq=%b sram=%h start=%b, want all 0",
                 c, CPU_RDATA, CPU_RVALID, CPU_IRQ, SRAM_WE, CORE_START);
      else passed++;
    end
    do_read(CTRL_BASE + 18'h4, d, v);
    total++;
    if (v !== 1'b1 || d !== 32'h0)
      $display("[TB] FAIL reset_status_read: got valid=%b data=%h, want valid=1 data=0", v, d);
    else passed++;
    @(negedge CLK);
    total++;
    if (CPU_RVALID !== 1'b0 || CPU_RDATA !== 32'h0)
      $display("[TB] FAIL rvalid_drop: got valid=%b data=%h, want 0/0", CPU_RVALID, CPU_RDATA);
    else passed++;
  endtask

  // Write strobe decode: directed pages then random addresses (control page excluded)
  task automatic test_write_decode();
    logic [17:0] adr;
    logic [31:0] data;
    logic [45:0] exp_sram;
    int pg;
    for (int n = 0; n < 34; n++) begin
      case (n)
        0: begin adr = 18'h2D010; data = 32'hDEADBEEF; end
        1: begin adr = 18'h2E000; data = $urandom; end
        2: begin adr = 18'h30000; data = $urandom; end
        3: begin adr = 18'h2F000; data = $urandom; end
        default: begin
          pg = $urandom_range(0, 63);
          if (pg == 50) pg = 51;
          adr = {6'(pg), 12'($urandom_range(0, 4095))};
          data = $urandom;
        end
      endcase
      pg = int'(adr[17:12]);
      exp_sram = (pg < NUM_BANK) ? (46'd1 << pg) : '0;
      do_write(adr, data);
      total++;
      if (SRAM_WE !== exp_sram || BIAS_WE !== (pg == 46) || IMAGE_WE !== (pg == 48))
        $display("[TB] FAIL wr_strobe adr=%h: got sram=%h bias=%b image=%b, want sram=%h bias=%b image=%b",
                 adr, SRAM_WE, BIAS_WE, IMAGE_WE, exp_sram, pg == 46, pg == 48);
      else passed++;
      total++;
      if (MEM_ADR !== adr[11:2] || MEM_WDATA !== data)
        $display("[TB] FAIL wr_capture adr=%h: got mem_adr=%h wdata=%h, want %h %h",
                 adr, MEM_ADR, MEM_WDATA, adr[11:2], data);
      else passed++;
      @(negedge CLK);
      total++;
      if (SRAM_WE !== '0 || BIAS_WE !== 1'b0 || IMAGE_WE !== 1'b0 || MEM_ADR !== adr[11:2] || MEM_WDATA !== data)
        $display("[TB] FAIL wr_idle adr=%h: got sram=%h bias=%b image=%b mem_adr=%h wdata=%h, want strobes 0 and held %h %h",
                 adr, SRAM_WE, BIAS_WE, IMAGE_WE, MEM_ADR, MEM_WDATA, adr[11:2], data);
      else passed++;
    end
  endtask

  // Result reads: directed indices including the first out-of-range one, then random
  task automatic test_result_read();
    logic [31:0] d;
    logic [31:0] exp;
    logic v;
    int pg;
    int k;
    for (int i = 0; i < NUM_RESULT; i++) result_words[i] = 32'h1000 + 32'(i);
    load_results();
    for (int n = 0; n < 30; n++) begin
      pg = 49;
      case (n)
        0: k = 0;
        1: k = 9;
        2: k = 10;
        3: k = 45;
        4: k = 46;
        default: begin
          if (n == 5) begin
            for (int i = 0; i < NUM_RESULT; i++) result_words[i] = $urandom;
            load_results();
          end
          if ($urandom_range(0, 3) == 0) pg = $urandom_range(0, 48);
          k = $urandom_range(0, 63);
        end
      endcase
      exp = (pg == 49 && k < NUM_RESULT) ? result_words[k] : 32'h0;
      do_read({6'(pg), 10'(k), 2'b00}, d, v);
      total++;
      if (v !== 1'b1 || d !== exp)
        $display("[TB] FAIL rd_result page=%0d k=%0d: got valid=%b data=%h, want valid=1 data=%h", pg, k, v, d, exp);
      else passed++;
      @(negedge CLK);
      total++;
      if (CPU_RVALID !== 1'b0 || CPU_RDATA !== 32'h0)
        $display("[TB] FAIL rd_after k=%0d: got valid=%b data=%h, want 0/0", k, CPU_RVALID, CPU_RDATA);
      else passed++;
    end
  endtask

  // One complete run: START, a mid-run START rewrite, a mid-run CYCLES read,
  // CORE_DONE after len cycles, optional DONE clear colliding with the set,
  // then status, counter, interrupt and clear checks
  task automatic test_run(input int len, input int wr_k, input int rd_k,
                          input bit w1c_at_done, input bit en_start, input bit en_mid);
    logic [31:0] d;
    logic v;
    do_write(CTRL_BASE, {30'b0, en_start, 1'b1});
    model_irq_en = en_start;
    total++;
    if (CORE_START !== 1'b1)
      $display("[TB] FAIL core_start_pulse len=%0d: got %b, want 1", len, CORE_START);
    else passed++;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge CLK);
      if (k == rd_k + 1) begin
        CPU_RD = 1'b0;
        total++;
        if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 32'(rd_k))
          $display("[TB] FAIL midrun_cycles k=%0d: got valid=%b data=%0d, want 1 %0d", rd_k, CPU_RVALID, CPU_RDATA, rd_k);
        else passed++;
      end
      if (k == wr_k + 1) CPU_WR = 1'b0;
      if (k == len + 1) begin
        CORE_DONE = 1'b0;
        CPU_WR = 1'b0;
      end
      total++;
      if (CORE_START !== 1'b0)
        $display("[TB] FAIL extra_core_start k=%0d: got %b, want 0", k, CORE_START);
      else passed++;
      if (k == rd_k) begin
        CPU_ADR = CTRL_BASE + 18'h8;
        CPU_RD = 1'b1;
      end
      if (k == wr_k) begin
        CPU_ADR = CTRL_BASE;
        CPU_WDATA = {30'b0, en_mid, 1'b1};
        CPU_WR = 1'b1;
        model_irq_en = en_mid;
      end
      if (k == len) begin
        CORE_DONE = 1'b1;
        if (w1c_at_done) begin
          CPU_ADR = CTRL_BASE + 18'h4;
          CPU_WDATA = 32'h2;
          CPU_WR = 1'b1;
        end
      end
    end
    total++;
    if (CPU_IRQ !== 1'b0)
      $display("[TB] FAIL irq_early len=%0d: got %b, want 0", len, CPU_IRQ);
    else passed++;
    do_read(CTRL_BASE + 18'h4, d, v);
    total++;
    if (v !== 1'b1 || d !== 32'h2)
      $display("[TB] FAIL status_done len=%0d: got valid=%b data=%h, want 1 00000002", len, v, d);
    else passed++;
    total++;
    if (CPU_IRQ !== model_irq_en)
      $display("[TB] FAIL irq_level len=%0d: got %b, want %b", len, CPU_IRQ, model_irq_en);
    else passed++;
    do_read(CTRL_BASE + 18'h8, d, v);
    last_cycles = len;
    total++;
    if (v !== 1'b1 || d !== 32'(len))
      $display("[TB] FAIL cycles_final: got valid=%b data=%0d, want 1 %0d", v, d, len);
    else passed++;
    do_read(CTRL_BASE, d, v);
    total++;
    if (d !== {30'b0, model_irq_en, 1'b0})
      $display("[TB] FAIL ctrl_read: got %h, want %h", d, {30'b0, model_irq_en, 1'b0});
    else passed++;
    do_write(CTRL_BASE + 18'h4, 32'h2);
    @(negedge CLK);
    total++;
    if (CPU_IRQ !== 1'b0)
      $display("[TB] FAIL irq_clear: got %b, want 0", CPU_IRQ);
    else passed++;
    do_read(CTRL_BASE + 18'h4, d, v);
    total++;
    if (d !== 32'h0)
      $display("[TB] FAIL status_cleared: got %h, want 00000000", d);
    else passed++;
  endtask

  // CORE_DONE while idle must not set DONE, start anything or touch CYCLES
  task automatic test_idle_done();
    logic [31:0] d;
    logic v;
    CORE_DONE = 1'b1;
    @(negedge CLK);
    CORE_DONE = 1'b0;
    @(negedge CLK);
    total++;
    if (CORE_START !== 1'b0 || CPU_IRQ !== 1'b0)
      $display("[TB] FAIL idle_done_outputs: got start=%b irq=%b, want 0 0", CORE_START, CPU_IRQ);
    else passed++;
    do_read(CTRL_BASE + 18'h4, d, v);
    total++;
    if (d !== 32'h0)
      $display("[TB] FAIL idle_done_status: got %h, want 00000000", d);
    else passed++;
    do_read(CTRL_BASE + 18'h8, d, v);
    total++;
    if (d !== 32'(last_cycles))
      $display("[TB] FAIL idle_done_cycles: got %0d, want %0d", d, last_cycles);
    else passed++;
  endtask

  // Asynchronous reset in the middle of a run
  task automatic test_reset_mid_run();
    logic [31:0] d;
    logic v;
    do_write(CTRL_BASE, 32'h3);
    repeat (20) @(negedge CLK);
    RESET_X = 1'b0;
    #1;
    total++;
    if ({CPU_RDATA, CPU_RVALID, CPU_IRQ, SRAM_WE, BIAS_WE, IMAGE_WE, MEM_ADR, MEM_WDATA, CORE_START} !== '0)
      $display("[TB] FAIL async_reset_outputs: got mem_adr=%h wdata=%h start=%b, want all 0", MEM_ADR, MEM_WDATA, CORE_START);
    else passed++;
    @(negedge CLK);
    RESET_X = 1'b1;
    model_irq_en = 1'b0;
    last_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      total++;
      if (CORE_START !== 1'b0)
        $display("[TB] FAIL start_after_reset cycle %0d: got %b, want 0", c, CORE_START);
      else passed++;
    end
    do_read(CTRL_BASE + 18'h4, d, v);
    total++;
    if (d !== 32'h0)
      $display("[TB] FAIL reset_busy: got status %h, want 00000000", d);
    else passed++;
    do_read(CTRL_BASE + 18'h8, d, v);
    total++;
    if (d !== 32'h0)
      $display("[TB] FAIL reset_cycles: got %0d, want 0", d);
    else passed++;
    do_read(CTRL_BASE, d, v);
    total++;
    if (d !== 32'h0)
      $display("[TB] FAIL reset_irq_en: got ctrl %h, want 00000000", d);
    else passed++;
  endtask

  // Write and read in the same cycle: write happens, read returns 0 with valid
  task automatic test_back_to_back();
    logic [31:0] data;
    logic [31:0] d;
    logic v;
    for (int i = 0; i < NUM_RESULT; i++) result_words[i] = 32'h1000 + 32'(i);
    load_results();
    data = $urandom;
    CPU_ADR = 18'h03020;
    CPU_WDATA = data;
    CPU_WR = 1'b1;
    CPU_RD = 1'b1;
    @(negedge CLK);
    CPU_WR = 1'b0;
    CPU_RD = 1'b0;
    total++;
    if (SRAM_WE !== 46'd8 || MEM_ADR !== 10'd8 || MEM_WDATA !== data)
      $display("[TB] FAIL wrrd_bank3: got sram=%h mem_adr=%h wdata=%h, want 8 8 %h", SRAM_WE, MEM_ADR, MEM_WDATA, data);
    else passed++;
    total++;
    if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 32'h0)
      $display("[TB] FAIL wrrd_read: got valid=%b data=%h, want 1 0", CPU_RVALID, CPU_RDATA);
    else passed++;
    CPU_ADR = 18'h31004;
    CPU_WR = 1'b1;
    CPU_RD = 1'b1;
    @(negedge CLK);
    CPU_WR = 1'b0;
    CPU_RD = 1'b0;
    total++;
    if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 32'h0 || SRAM_WE !== '0 || BIAS_WE !== 1'b0 || IMAGE_WE !== 1'b0)
      $display("[TB] FAIL wrrd_result: got valid=%b data=%h sram=%h, want 1 0 0", CPU_RVALID, CPU_RDATA, SRAM_WE);
    else passed++;
    CPU_ADR = CTRL_BASE;
    CPU_WDATA = 32'h2;
    CPU_WR = 1'b1;
    CPU_RD = 1'b1;
    @(negedge CLK);
    CPU_WR = 1'b0;
    CPU_RD = 1'b0;
    total++;
    if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 32'h0)
      $display("[TB] FAIL wrrd_ctrl: got valid=%b data=%h, want 1 0", CPU_RVALID, CPU_RDATA);
    else passed++;
    do_read(CTRL_BASE, d, v);
    total++;
    if (d !== 32'h2)
      $display("[TB] FAIL wrrd_ctrl_written: got %h, want 00000002", d);
    else passed++;
    do_write(CTRL_BASE, 32'h0);
    model_irq_en = 1'b0;
  endtask

  // Test sequence
  initial begin
    int len;
    passed = 0;
    total = 0;
    test_reset();
    test_write_decode();
    test_result_read();
    test_run(100, 30, 50, 1'b0, 1'b1, 1'b1);
    test_idle_done();
    test_run(40, 5, 30, 1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(10, 150);
      test_run(len, $urandom_range(1, len / 2 - 1), $urandom_range(len / 2, len - 1),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
